// File: rtl/gf2mz_vec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gf2mz_vec_unit : word-serial ADD / SCALE / MAC over GF(2^m)[z] RAM words |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

module gf2m_mul #(
  parameter int M   = 83,
  parameter int K3  = 7,
  parameter int K2  = 4,
  parameter int K1  = 2,
  parameter int DIG = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start_i,
  input  logic [M-1:0] op_a_i,
  input  logic [M-1:0] op_b_i,
  output logic [M-1:0] op_c_o,
  output logic         done_o
);

  localparam int NDIG = (M + DIG - 1) / DIG;
  localparam int BW   = NDIG * DIG;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [M-1:0] RED = (M'(1) << K3) | (M'(1) << K2) | (M'(1) << K1) | M'(1);

  logic [M-1:0]  a_q;
  logic [BW-1:0] b_q;
  logic [M-1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic          done_q;

  // MSB-first Horner step over one digit of b: acc = acc*x^DIG + a*digit mod f
  function automatic logic [M-1:0] digit_step(input logic [M-1:0] acc,
                                              input logic [M-1:0] a,
                                              input logic [DIG-1:0] dig);
    logic [M-1:0] r;
    r = acc;
    for (int i = DIG - 1; i >= 0; i--) begin
      r = {r[M-2:0], 1'b0} ^ (r[M-1] ? RED : {M{1'b0}});
      if (dig[i]) r = r ^ a;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= op_a_i;
      b_q    <= BW'(op_b_i);
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      acc_q <= digit_step(acc_q, a_q, b_q[BW-1 -: DIG]);
      b_q   <= b_q << DIG;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(NDIG - 1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign op_c_o = acc_q;
  assign done_o = done_q;

endmodule

module gf2mz_vec_unit #(
  parameter int N       = 149,
  parameter int M       = 83,
  parameter int D       = 5,
  parameter int WIDTH   = M * D,
  parameter int DEPTH   = (N + D - 1) / D,
  parameter int AW      = $clog2(DEPTH),
  parameter int K3      = 7,
  parameter int K2      = 4,
  parameter int K1      = 2,
  parameter int MUL_DIG = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [M-1:0]     scalar,
  input  logic [WIDTH-1:0] A_di,
  output logic [AW-1:0]    A_addr,
  input  logic [WIDTH-1:0] B_di,
  output logic [AW-1:0]    B_addr,
  input  logic [WIDTH-1:0] C_di,
  output logic [AW-1:0]    C_addr,
  output logic             C_we,
  output logic [WIDTH-1:0] C_do,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RW   = 3'd2,
    S_MS   = 3'd3,
    S_MW   = 3'd4,
    S_WR   = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    w_q, w_d;
  logic [1:0]       op_q, op_d;
  logic [M-1:0]     scalar_q, scalar_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] cin_q, cin_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] pad_mask;
  logic [WIDTH-1:0] word_mask;
  logic [WIDTH-1:0] prod;
  logic [D-1:0]     lane_done;
  logic             all_done;
  logic             mul_start;
  logic             is_mac;
  logic             is_mul;

  // Lanes past coefficient N-1 in the last word are always written as zero
  for (genvar j = 0; j < D; j++) begin : g_pad
    assign pad_mask[WIDTH-1-j*M -: M] = ((DEPTH - 1) * D + j >= N) ? {M{1'b0}} : {M{1'b1}};
  end

  for (genvar j = 0; j < D; j++) begin : g_lane
    gf2m_mul #(
      .M  (M),
      .K3 (K3),
      .K2 (K2),
      .K1 (K1),
      .DIG(MUL_DIG)
    ) u_mul (
      .clk    (clk),
      .rst_b  (rst_b),
      .start_i(mul_start),
      .op_a_i (opa_q[WIDTH-1-j*M -: M]),
      .op_b_i (scalar_q),
      .op_c_o (prod[WIDTH-1-j*M -: M]),
      .done_o (lane_done[j])
    );
  end

  assign all_done  = &lane_done;
  assign mul_start = (state_q == S_MS);
  assign is_mac    = (op_q == 2'b10);
  assign is_mul    = (op_q == 2'b01) || is_mac;
  assign word_mask = (w_q == LAST) ? pad_mask : {WIDTH{1'b1}};

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    op_d     = op_q;
    scalar_d = scalar_q;
    opa_d    = opa_q;
    cin_d    = cin_q;
    res_d    = res_q;
    we_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          scalar_d = scalar;
          w_d      = '0;
          busy_d   = 1'b1;
          state_d  = S_RD;
        end
      end
      S_RD: state_d = S_RW;
      S_RW: begin
        if (is_mul) begin
          opa_d = A_di;
          if (is_mac) cin_d = C_di;
          state_d = S_MS;
        end else begin
          res_d   = (A_di ^ B_di) & word_mask;
          we_d    = 1'b1;
          state_d = S_WR;
        end
      end
      S_MS: state_d = S_MW;
      S_MW: begin
        if (all_done) begin
          res_d   = (prod ^ (is_mac ? cin_q : {WIDTH{1'b0}})) & word_mask;
          we_d    = 1'b1;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (w_q == LAST) begin
          state_d = S_FIN;
        end else begin
          w_d     = w_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      op_q     <= '0;
      scalar_q <= '0;
      opa_q    <= '0;
      cin_q    <= '0;
      res_q    <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      op_q     <= op_d;
      scalar_q <= scalar_d;
      opa_q    <= opa_d;
      cin_q    <= cin_d;
      res_q    <= res_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign A_addr = w_q;
  assign B_addr = w_q;
  assign C_addr = w_q;
  assign C_we   = we_q;
  assign C_do   = res_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_gf2mz_vec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gf2mz_vec_unit : randomized bench with polynomial-arithmetic model    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

module tb_gf2mz_vec_unit;

  localparam int N       = 149;
  localparam int M       = 83;
  localparam int D       = 5;
  localparam int WIDTH   = M * D;
  localparam int DEPTH   = (N + D - 1) / D;
  localparam int AW      = $clog2(DEPTH);
  localparam int K3      = 7;
  localparam int K2      = 4;
  localparam int K1      = 2;
  localparam int MUL_DIG = 16;
  localparam int BUDGET  = 4000;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             start;
  logic [1:0]       op;
  logic [M-1:0]     scalar;
  logic [WIDTH-1:0] A_di, B_di, C_di;
  logic [AW-1:0]    A_addr, B_addr, C_addr;
  logic             C_we;
  logic [WIDTH-1:0] C_do;
  logic             busy, done;

  logic [WIDTH-1:0] memA  [DEPTH];
  logic [WIDTH-1:0] memB  [DEPTH];
  logic [WIDTH-1:0] memC  [DEPTH];
  logic [WIDTH-1:0] cinit [DEPTH];
  logic [WIDTH-1:0] prevC [DEPTH];
  logic [WIDTH-1:0] expC  [DEPTH];
  logic             c_load;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gf2mz_vec_unit #(
    .N(N), .M(M), .D(D), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW),
    .K3(K3), .K2(K2), .K1(K1), .MUL_DIG(MUL_DIG)
  ) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .scalar(scalar),
    .A_di(A_di), .A_addr(A_addr), .B_di(B_di), .B_addr(B_addr),
    .C_di(C_di), .C_addr(C_addr), .C_we(C_we), .C_do(C_do),
    .busy(busy), .done(done)
  );

  // Synchronous-read RAMs; C also accepts a bulk preload from the bench
  always @(posedge clk) begin
    A_di <= memA[A_addr];
    B_di <= memB[B_addr];
    C_di <= memC[C_addr];
    if (c_load) begin
      for (int i = 0; i < DEPTH; i++) memC[i] <= cinit[i];
    end else if (C_we) begin
      memC[C_addr] <= C_do;
    end
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Schoolbook carry-less product, then reduction modulo x^M+x^K3+x^K2+x^K1+1
  function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-1:0] p;
    logic [2*M-1:0] f;
    p = '0;
    f = '0;
    f[M] = 1'b1; f[K3] = 1'b1; f[K2] = 1'b1; f[K1] = 1'b1; f[0] = 1'b1;
    for (int i = 0; i < M; i++)
      if (b[i]) p = p ^ ((2*M)'(a) << i);
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) p = p ^ (f << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < (WIDTH + 31) / 32; i++) v = (v << 32) | WIDTH'($urandom);
    return v;
  endfunction

  function automatic logic [M-1:0] rand_coef();
    logic [M-1:0] v;
    v = '0;
    for (int i = 0; i < (M + 31) / 32; i++) v = (v << 32) | M'($urandom);
    return v;
  endfunction

  task automatic compute_exp(input logic [1:0] o, input logic [M-1:0] s);
    logic [M-1:0] a, b, c, r;
    for (int w = 0; w < DEPTH; w++) begin
      expC[w] = '0;
      for (int j = 0; j < D; j++) begin
        a = memA[w][WIDTH-1-j*M -: M];
        b = memB[w][WIDTH-1-j*M -: M];
        c = prevC[w][WIDTH-1-j*M -: M];
        if (w * D + j >= N)   r = '0;
        else if (o == 2'b01)  r = gmul(s, a);
        else if (o == 2'b10)  r = c ^ gmul(s, a);
        else                  r = a ^ b;
        expC[w][WIDTH-1-j*M -: M] = r;
      end
    end
  endtask

  task automatic load_c(input bit randomize_words);
    for (int w = 0; w < DEPTH; w++) cinit[w] = randomize_words ? rand_word() : '0;
    @(negedge clk); c_load = 1'b1;
    @(negedge clk); c_load = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int w = 0; w < DEPTH; w++) check($sformatf("%s_w%0d", tag, w), memC[w], expC[w]);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [M-1:0] s, input int disturb,
                        output int cyc, output int wec);
    bit got_done;
    for (int w = 0; w < DEPTH; w++) prevC[w] = memC[w];
    compute_exp(o, s);
    @(negedge clk);
    op = o; scalar = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 0; wec = 0; got_done = 0;
    while (!got_done && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (C_we) begin
        wec++;
        if (int'(C_addr) == disturb) begin
          start = 1'b1; op = 2'b00; scalar = rand_coef();
        end
      end
      if (done) got_done = 1;
    end
    check("done_seen", got_done, 1);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, wec, waited;
    logic [M-1:0] s;
    logic [WIDTH-1:0] wv;

    rst_b = 1'b0; start = 1'b0; op = 2'b00; scalar = '0; c_load = 1'b0;
    for (int w = 0; w < DEPTH; w++) begin memA[w] = '0; memB[w] = '0; end
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", C_we, 0);
    check("rst_addr", {A_addr, B_addr, C_addr}, 0);
    check("rst_cdo", C_do, 0);
    @(negedge clk); rst_b = 1'b1;
    load_c(0);

    // ADD: word k lanes = k, B lanes = 1
    for (int k = 0; k < DEPTH; k++)
      for (int j = 0; j < D; j++) begin
        memA[k][WIDTH-1-j*M -: M] = M'(k);
        memB[k][WIDTH-1-j*M -: M] = M'(1);
      end
    run_op(2'b00, rand_coef(), -1, cyc, wec);
    check("add_cycles", cyc, 3 * DEPTH + 1);
    check("add_we_count", wec, DEPTH);
    check_mem("add");
    check("add_w0_l0", memC[0][WIDTH-1 -: M], 1);
    check("add_w29_l4", memC[DEPTH-1][WIDTH-1-(D-1)*M -: M], 0);

    // reserved op behaves as ADD
    for (int w = 0; w < DEPTH; w++) begin memA[w] = rand_word(); memB[w] = rand_word(); end
    run_op(2'b11, rand_coef(), -1, cyc, wec);
    check("op11_cycles", cyc, 3 * DEPTH + 1);
    check_mem("op11");

    // SCALE by one and by zero
    run_op(2'b01, M'(1), -1, cyc, wec);
    check("scale1_we_count", wec, DEPTH);
    check_mem("scale1");
    run_op(2'b01, '0, -1, cyc, wec);
    for (int w = 0; w < DEPTH; w++) check($sformatf("scale0_w%0d", w), memC[w], 0);

    // MAC by zero leaves C except the padded lane
    load_c(1);
    run_op(2'b10, '0, -1, cyc, wec);
    check_mem("mac0");

    // MAC twice from zero cancels
    load_c(0);
    for (int w = 0; w < DEPTH; w++) memA[w] = rand_word();
    s = rand_coef();
    run_op(2'b10, s, -1, cyc, wec);
    check_mem("mac_first");
    run_op(2'b10, s, -1, cyc, wec);
    for (int w = 0; w < DEPTH; w++) check($sformatf("mac_cancel_w%0d", w), memC[w], 0);

    // SCALE with a stray start and op change during word 10
    s = rand_coef();
    run_op(2'b01, s, 10, cyc, wec);
    check("disturb_we_count", wec, DEPTH);
    check_mem("scale_disturb");

    // random MAC over random C
    load_c(1);
    for (int w = 0; w < DEPTH; w++) memA[w] = rand_word();
    run_op(2'b10, rand_coef(), -1, cyc, wec);
    check_mem("mac_rand");

    // reset during the multiply wait of word 12
    load_c(1);
    for (int w = 0; w < DEPTH; w++) begin memA[w] = rand_word(); prevC[w] = memC[w]; end
    s = rand_coef();
    compute_exp(2'b01, s);
    @(negedge clk);
    op = 2'b01; scalar = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!(C_we && C_addr == AW'(11)) && waited < BUDGET) begin
      @(posedge clk); #1;
      waited++;
    end
    check("abort_reached_w11", (waited < BUDGET), 1);
    repeat (4) @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_we", C_we, 0);
    check("abort_cdo", C_do, 0);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_b = 1'b1;
    repeat (5) @(posedge clk);
    for (int w = 0; w < DEPTH; w++) begin
      wv = (w < 12) ? expC[w] : prevC[w];
      check($sformatf("abort_mem_w%0d", w), memC[w], wv);
    end

    // fresh run after the abort
    run_op(2'b01, rand_coef(), -1, cyc, wec);
    check("fresh_we_count", wec, DEPTH);
    check_mem("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gf2mz_vec_unit.md
Name: gf2mz_vec_unit

Overview:
- Parametrised vector engine for GF(2^m)[z] polynomials held in word-organised block RAM; each word packs D coefficients of M bits.
- Performs one of three digit-serial operations over all DEPTH words:
  - ADD: C = A + B
  - SCALE: C = s·A, with s a GF(2^m) scalar
  - MAC: C = C + s·A
- Sits beside the polynomial multiplier in the ROLLO encrypt datapath and serves the additions and scalar updates that the multiplier cannot do.
- Instantiates D gf2m_mul lanes through a generate loop.

Parameters:
- N, 149, number of polynomial coefficients.
- M, 83, GF(2^m) field degree (coefficient width).
- D, 5, coefficients per memory word (lane count).
- WIDTH, M*D, memory word width.
- DEPTH, ceil(N/D), words per polynomial.
- AW, clog2(DEPTH), address width.
- K3, 7, field pentanomial term passed to gf2m_mul.
- K2, 4, field pentanomial term passed to gf2m_mul.
- K1, 2, field pentanomial term passed to gf2m_mul.
- MUL_DIG, 16, gf2m_mul digit size.

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  00=ADD, 01=SCALE, 10=MAC, 11=reserved (treated as ADD)
- scalar  in  M  s for SCALE/MAC; latched on accepted start
- A_di  in  WIDTH  read data from memory A
- A_addr  out  AW  address to memory A
- B_di  in  WIDTH  read data from memory B
- B_addr  out  AW  address to memory B
- C_di  in  WIDTH  read data from memory C (MAC only)
- C_addr  out  AW  address to memory C
- C_we  out  1  write enable for memory C
- C_do  out  WIDTH  write data to memory C
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Memory and word layout
  - All memories read synchronously with 1-cycle latency.
  - Lane j of word w occupies bits [WIDTH-1-j*M -: M] and holds coefficient w*D+j.
- Reset (rst_b low, asynchronous)
  - FSM returns to IDLE.
  - busy=0, done=0, C_we=0, all addresses=0, C_do=0, latched op and scalar cleared.
  - Reset mid-operation abandons the run. Words already written stay written; no further writes occur.
- FSM states and transitions
  - IDLE: on start=1, latch op and scalar, set word counter w=0, busy=1, go to RD.
  - RD: drive A_addr=B_addr=C_addr=w; go to RW.
  - RW: data valid this cycle.
    - ADD: capture A_di^B_di; go to WR.
    - SCALE/MAC: capture A_di into D lane operand registers (op_b=scalar); capture C_di for MAC; go to MS.
  - MS: pulse gf2m_mul start for all D lanes for exactly one cycle; go to MW.
  - MW: wait until the AND of all D lane done signals is high. Capture op_c per lane; for MAC, XOR with the captured C lane. Go to WR.
  - WR: C_we=1 for one cycle, C_addr=w, C_do=result.
    - If w==DEPTH-1, go to FIN.
    - Otherwise w=w+1 and go to RD.
  - FIN: done=1 for one cycle, busy=0 on the next edge, return to IDLE.
- Padding: in word DEPTH-1, lanes j with (DEPTH-1)*D+j >= N are forced to zero in C_do regardless of operand contents. With defaults, lane 4 of word 29 is zeroed.
- Timing
  - ADD: done asserts exactly 3*DEPTH+1 cycles after the accepted start edge (90+1 for defaults).
  - SCALE/MAC: each word costs 4+L cycles, where L is the gf2m_mul start-to-done latency; done depends on L only through the done handshake.
- start while busy is ignored; the run in flight is unaffected.
- start on the same cycle as FIN is ignored; a new start is accepted the next cycle in IDLE.
- scalar or op changing during a run has no effect.
- C_we is never high outside WR.
- The word counter never exceeds DEPTH-1; no wrap-around write to address 0.

Test Plan:
- ADD, A word k all lanes = k, B all lanes = 0x1 → C lane = k^1 for every word; lane 4 of word 29 = 0; done at cycle 91 after start.
- SCALE, scalar=1, A random → C equals A except padded lane zeroed; exactly 30 C_we pulses.
- SCALE, scalar=0 → all C words 0. MAC, scalar=0 → C unchanged except padded lane zeroed.
- MAC run twice with the same A and s, C initially 0 → C returns to 0 (GF(2) cancellation), confirming read-modify-write order.
- start pulsed again at word 10 of a SCALE run, plus op switched to ADD → ignored; result identical to an undisturbed run.
- rst_b low during MW of word 12 → busy, done, C_we drop immediately; words 0–11 written, words 12–29 untouched; a following fresh start completes correctly.
